// File: rtl/systolic_ctrl.sv
// Sequencer for a weight-stationary PE array: loads a weight tile row by row,
// streams activation vectors through the array and drains the pipeline.
module systolic_ctrl #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int ADDR_W   = 10,
   parameter int VEC_W    = 12,
   parameter int PIPE_LAT = ROWS + COLS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [VEC_W-1:0]  cfg_num_vec,
   input  logic [ADDR_W-1:0] cfg_w_base,
   input  logic [ADDR_W-1:0] cfg_a_base,
   input  logic              cfg_reuse_w,
   input  logic              res_ready,
   output logic              busy,
   output logic              done,
   output logic              wgt_rd_en,
   output logic [ADDR_W-1:0] wgt_rd_addr,
   output logic [ROWS-1:0]   load_weight_row,
   output logic              act_rd_en,
   output logic [ADDR_W-1:0] act_rd_addr,
   output logic              en_compute,
   output logic              res_valid,
   output logic [VEC_W-1:0]  res_idx
);

   localparam int LC_W = $clog2(ROWS + 1);
   localparam logic [LC_W-1:0]  LC_LAST = LC_W'(ROWS);
   localparam logic [VEC_W:0]   PIPE_C  = (VEC_W + 1)'(PIPE_LAT);
   localparam logic [ROWS-1:0]  ROW0    = ROWS'(1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      COMPUTE,
      DRAIN,
      DONE
   } state_t;

   state_t             state, state_nx;
   logic [LC_W-1:0]    lc, lc_nx;
   logic [VEC_W:0]     cc, cc_nx;
   logic [VEC_W-1:0]   num_vec;
   logic [ADDR_W-1:0]  w_base;
   logic [ADDR_W-1:0]  a_base;
   logic [VEC_W:0]     num_vec_ext;
   logic [VEC_W:0]     cc_last;
   logic               running;

   assign num_vec_ext = {1'b0, num_vec};
   assign cc_last     = num_vec_ext + PIPE_C - 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         lc      <= '0;
         cc      <= '0;
         num_vec <= '0;
         w_base  <= '0;
         a_base  <= '0;
      end else begin
         state <= state_nx;
         lc    <= lc_nx;
         cc    <= cc_nx;
         if (state == IDLE && start) begin
            num_vec <= cfg_num_vec;
            w_base  <= cfg_w_base;
            a_base  <= cfg_a_base;
         end
      end
   end

   always_comb begin
      state_nx = state;
      lc_nx    = lc;
      cc_nx    = cc;
      case (state)
         IDLE: begin
            if (start) begin
               lc_nx = '0;
               cc_nx = '0;
               if (!cfg_reuse_w)           state_nx = LOAD_W;
               else if (cfg_num_vec != '0) state_nx = COMPUTE;
               else                        state_nx = DONE;
            end
         end
         LOAD_W: begin
            if (lc == LC_LAST) begin
               cc_nx    = '0;
               state_nx = (num_vec == '0) ? DONE : COMPUTE;
            end else begin
               lc_nx = lc + 1'b1;
            end
         end
         COMPUTE: begin
            if (res_ready) begin
               cc_nx = cc + 1'b1;
               if (cc_nx == num_vec_ext) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (res_ready) begin
               cc_nx = cc + 1'b1;
               if (cc == cc_last) state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign running = (state == COMPUTE) || (state == DRAIN);

   // Weight buffer has one cycle of read latency, so the row enable trails lc by one.
   always_comb begin
      busy            = (state == LOAD_W) || running;
      done            = (state == DONE);
      wgt_rd_en       = (state == LOAD_W) && (lc < LC_LAST);
      wgt_rd_addr     = (state == LOAD_W) ? w_base + ADDR_W'(lc) : '0;
      load_weight_row = (state == LOAD_W && lc != '0) ? ROW0 << (lc - 1'b1) : '0;
      en_compute      = running && res_ready;
      act_rd_en       = running && res_ready && (cc < num_vec_ext);
      act_rd_addr     = running ? a_base + ADDR_W'(cc) : '0;
      res_valid       = running && res_ready && (cc >= PIPE_C);
      res_idx         = res_valid ? VEC_W'(cc - PIPE_C) : '0;
   end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the weight-stationary PE array (ROWS x COLS PEs): loads one weight tile row-by-row, then streams M activation vectors and drains the pipeline.
- Drives the array's per-row load_weight enables and the global en_compute; issues reads to the weight and activation buffers; flags deskewed results as valid.
- Sits between the layer-level scheduler (start/done) and the array plus its on-chip buffers.

Parameters:
- ROWS, 8, array rows; number of weight-load steps.
- COLS, 8, array columns; documents the array size, no port uses it.
- ADDR_W, 10, buffer address width.
- VEC_W, 12, width of the vector count and result index.
- PIPE_LAT, ROWS+COLS, compute cycles from the first act_rd_en until the first valid result (1 buffer read + array skew/depth).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch pulse; accepted only in IDLE
- cfg_num_vec  in  VEC_W  M, number of activation vectors; latched at start
- cfg_w_base  in  ADDR_W  weight-buffer base address; latched at start
- cfg_a_base  in  ADDR_W  activation-buffer base address; latched at start
- cfg_reuse_w  in  1  1 = skip weight load and keep the resident tile; latched at start
- res_ready  in  1  downstream ready; 0 freezes compute
- busy  out  1  high in LOAD_W, COMPUTE, DRAIN
- done  out  1  one-cycle pulse at job end
- wgt_rd_en  out  1  weight-buffer read strobe
- wgt_rd_addr  out  ADDR_W  weight-buffer read address
- load_weight_row  out  ROWS  one-hot per-row load_weight enable
- act_rd_en  out  1  activation-buffer read strobe
- act_rd_addr  out  ADDR_W  activation-buffer read address
- en_compute  out  1  array-wide compute enable
- res_valid  out  1  result vector at the array bottom edge is valid
- res_idx  out  VEC_W  index of the current valid result vector (0..M-1)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state returns to IDLE. All outputs go to 0, the counters go to 0 and the latched config goes to 0. Reset mid-job aborts the job immediately with no done pulse.
- All outputs are registered or decoded from registered state only; no combinational input-to-output path except the res_ready gating described below.
- States: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
- Transitions out of IDLE on start:
  - cfg_reuse_w=0: go to LOAD_W, lc=0.
  - cfg_reuse_w=1 and M>0: go to COMPUTE, cc=0.
  - cfg_reuse_w=1 and M=0: go to DONE.
- start outside IDLE is ignored.
- LOAD_W (ROWS+1 cycles, lc = 0..ROWS, never stalled by res_ready):
  - wgt_rd_en=1 while lc<ROWS; wgt_rd_addr = w_base+lc.
  - The buffer has 1-cycle read latency, so load_weight_row = onehot(lc-1) while lc>=1. Row 0 loads at lc=1 and row ROWS-1 loads at lc=ROWS.
  - en_compute=0 throughout.
  - At lc=ROWS: go to COMPUTE (cc=0), or to DONE if M=0.
- COMPUTE (cc<M) and DRAIN (M<=cc<M+PIPE_LAT):
  - en_compute=res_ready.
  - act_rd_en = res_ready && cc<M; act_rd_addr = a_base+cc.
  - res_valid = res_ready && PIPE_LAT<=cc<M+PIPE_LAT; res_idx = cc-PIPE_LAT when valid, otherwise 0.
  - cc increments only when res_ready=1.
  - COMPUTE goes to DRAIN when cc reaches M.
  - DRAIN goes to DONE after the cycle with cc=M+PIPE_LAT-1 and res_ready=1.
- Stall (res_ready=0): every strobe is 0 and cc, state and addresses hold. The activation buffer is required to hold its read data while act_rd_en=0, so the array resumes bit-exact.
- DONE: lasts one cycle with done=1 and busy=0, then goes to IDLE. A start in the DONE cycle is ignored.
- Arithmetic: address adds wrap modulo 2^ADDR_W. cc is VEC_W+1 bits wide so M+PIPE_LAT cannot overflow. M=2^VEC_W-1 is legal.
- Weights stay resident across jobs; cfg_reuse_w=1 after reset uses all-zero weights (no error raised).

Test Plan:
All scenarios use ROWS=COLS=4 and PIPE_LAT=8.
- Basic job: start with M=3, w_base=0x10, a_base=0x40, reuse=0, res_ready=1.
  - Required: wgt_rd_addr 0x10..0x13 over 4 cycles; load_weight_row 0001, 0010, 0100, 1000 one cycle later each.
  - Then en_compute high for 11 cycles; act_rd_addr 0x40..0x42 on the first 3 of them.
  - res_valid on compute cycles 8..10 with res_idx 0,1,2; done one cycle later; busy high from the cycle after start until done.
- Reuse: reuse=1, M=2. Required: no wgt_rd_en and no load_weight_row; COMPUTE is entered the cycle after start; en_compute for 10 cycles; res_idx 0,1.
- Stall: M=3, res_ready low for 2 cycles at cc=1 and for 3 cycles at cc=9.
  - Required: during the low cycles, en_compute, act_rd_en and res_valid are 0 and addresses hold.
  - Total busy span grows by exactly 5 cycles; res_idx sequence is still 0,1,2.
- Edge cases:
  - M=0 with reuse=0: LOAD_W runs 5 cycles, then done; en_compute is never asserted.
  - M=0 with reuse=1: done pulses 1 cycle after start.
  - a_base=0x3FF with M=2: act_rd_addr 0x3FF then 0x000.
- Reset mid-job: assert rst at cc=5. Required: next cycle all outputs are 0, state is IDLE, and no done pulse; a fresh start then runs the basic job correctly.
- Ignored start: pulse start during COMPUTE and again during DONE. Required: no effect on the current job, and the latched config is unchanged.
